// File: rtl/camera_frame_writer.sv
// rtl/camera_frame_writer.sv - packs 16-bit camera pixels into 128-bit words and queues DRAM writes
module camera_frame_writer #(
    parameter int          PIX_PER_WORD    = 8,
    parameter int          WORDS_PER_FRAME = 38400,
    parameter int          FIFO_DEPTH      = 4,
    parameter logic [24:0] ADDR_STEP       = 25'd4,
    parameter logic [24:0] FRAME_SPAN      = 25'h25800
) (
    input  logic           clk_133M,
    input  logic           rst_n_133M,
    input  logic           hdr_en,
    input  logic           frame_start,
    input  logic [15:0]    pixel_data,
    input  logic           pixel_valid,
    input  logic           ram_busy,
    output logic           camera_wr_req,
    output logic [127:0]   camera_data,
    output logic [24:0]    wr_address,
    output logic [2:0]     last_frame,
    output logic [1:0]     exposure_sel,
    output logic           frame_done_133M,
    output logic           overflow
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int PTRW = PW + 1;
    localparam int WCW  = $clog2(WORDS_PER_FRAME + 1);
    localparam int EW   = 25 + 128;

    logic [2:0]                    last_frame_q;
    logic [1:0]                    exposure_q;
    logic                          frame_done_q;
    logic                          overflow_q;
    logic                          req_q;
    logic [127:0]                  data_q;
    logic [24:0]                   addr_q;
    logic [2:0]                    pix_cnt_q;
    logic [WCW-1:0]                word_cnt_q;
    logic [24:0]                   push_addr_q;
    logic [PIX_PER_WORD-2:0][15:0] lanes_q;
    logic [PTRW-1:0]               wr_ptr_q;
    logic [PTRW-1:0]               rd_ptr_q;
    logic [EW-1:0]                 fifo_q [FIFO_DEPTH];

    logic [2:0]  last_frame_d;
    logic [1:0]  exposure_d;
    logic [24:0] base_d;

    always_comb begin
        if (!hdr_en)
            last_frame_d = 3'd0;
        else if (last_frame_q == 3'd5)
            last_frame_d = 3'd0;
        else
            last_frame_d = last_frame_q + 3'd1;
        exposure_d = (last_frame_d >= 3'd3) ? 2'(last_frame_d - 3'd3) : last_frame_d[1:0];
        base_d     = 25'(last_frame_d) * FRAME_SPAN;
    end

    logic          frame_full;
    logic          pix_take;
    logic          pix_drop;
    logic          word_done;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          push;
    logic [EW-1:0] head;

    assign frame_full = (word_cnt_q == WCW'(WORDS_PER_FRAME));
    assign pix_take   = pixel_valid && !frame_start && !frame_full;
    assign pix_drop   = pixel_valid && !frame_start && frame_full;
    assign word_done  = pix_take && (pix_cnt_q == 3'(PIX_PER_WORD - 1));
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = ((wr_ptr_q - rd_ptr_q) == PTRW'(FIFO_DEPTH));
    assign pop        = !fifo_empty && !ram_busy;
    // A full FIFO still accepts the word when the head leaves in the same cycle
    assign push       = word_done && (!fifo_full || pop);
    assign head       = fifo_q[rd_ptr_q[PW-1:0]];

    always_ff @(posedge clk_133M) begin
        if (push)
            fifo_q[wr_ptr_q[PW-1:0]] <= {push_addr_q, pixel_data, lanes_q};
    end

    always_ff @(posedge clk_133M or negedge rst_n_133M) begin
        if (!rst_n_133M) begin
            last_frame_q <= 3'd0;
            exposure_q   <= 2'd0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            req_q        <= 1'b0;
            data_q       <= '0;
            addr_q       <= '0;
            pix_cnt_q    <= 3'd0;
            word_cnt_q   <= '0;
            push_addr_q  <= 25'h0;
            lanes_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            frame_done_q <= frame_start;
            req_q        <= pop;
            if (pop) begin
                addr_q   <= head[EW-1:128];
                data_q   <= head[127:0];
                rd_ptr_q <= rd_ptr_q + PTRW'(1);
            end
            if (push)
                wr_ptr_q <= wr_ptr_q + PTRW'(1);
            if (frame_start) begin
                last_frame_q <= last_frame_d;
                exposure_q   <= exposure_d;
                push_addr_q  <= base_d;
                pix_cnt_q    <= 3'd0;
                word_cnt_q   <= '0;
                overflow_q   <= 1'b0;
            end else begin
                if (pix_take) begin
                    pix_cnt_q <= pix_cnt_q + 3'd1;
                    if (!word_done)
                        lanes_q[pix_cnt_q] <= pixel_data;
                end
                // Dropped words still advance the address so later words land correctly
                if (word_done) begin
                    word_cnt_q <= word_cnt_q + WCW'(1);
                    if (word_cnt_q != WCW'(WORDS_PER_FRAME - 1))
                        push_addr_q <= push_addr_q + ADDR_STEP;
                end
                if (pix_drop || (word_done && !push))
                    overflow_q <= 1'b1;
            end
        end
    end

    assign camera_wr_req   = req_q;
    assign camera_data     = data_q;
    assign wr_address      = addr_q;
    assign last_frame      = last_frame_q;
    assign exposure_sel    = exposure_q;
    assign frame_done_133M = frame_done_q;
    assign overflow        = overflow_q;

endmodule

// File: tb/tb_camera_frame_writer.sv
// tb/tb_camera_frame_writer.sv - randomized and directed bench for camera_frame_writer against a queue model
module tb_camera_frame_writer;
    localparam int          WPF  = 40;
    localparam logic [24:0] SPAN = 25'h25800;

    logic         clk_133M = 1'b0;
    logic         rst_n_133M = 1'b0;
    logic         hdr_en = 1'b0;
    logic         frame_start = 1'b0;
    logic [15:0]  pixel_data = '0;
    logic         pixel_valid = 1'b0;
    logic         ram_busy = 1'b0;
    logic         camera_wr_req;
    logic [127:0] camera_data;
    logic [24:0]  wr_address;
    logic [2:0]   last_frame;
    logic [1:0]   exposure_sel;
    logic         frame_done_133M;
    logic         overflow;

    camera_frame_writer #(.WORDS_PER_FRAME(WPF)) dut (
        .clk_133M        (clk_133M),
        .rst_n_133M      (rst_n_133M),
        .hdr_en          (hdr_en),
        .frame_start     (frame_start),
        .pixel_data      (pixel_data),
        .pixel_valid     (pixel_valid),
        .ram_busy        (ram_busy),
        .camera_wr_req   (camera_wr_req),
        .camera_data     (camera_data),
        .wr_address      (wr_address),
        .last_frame      (last_frame),
        .exposure_sel    (exposure_sel),
        .frame_done_133M (frame_done_133M),
        .overflow        (overflow)
    );

    always #5 clk_133M = ~clk_133M;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [152:0] act, input logic [152:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: a plain queue of pending {address, word} entries
    int           m_lf;
    bit           m_fd, m_ovf, m_req, m_pop;
    logic [24:0]  m_addr;
    logic [127:0] m_data;
    logic [127:0] m_word;
    logic [152:0] m_q[$];
    logic [15:0]  m_pix[$];
    int           m_wcnt, m_n;
    logic [152:0] act_log[$];
    logic [152:0] exp_log[$];
    int           fd_cnt;

    always @(posedge clk_133M or negedge rst_n_133M) begin
        if (!rst_n_133M) begin
            m_lf = 0; m_fd = 0; m_ovf = 0; m_req = 0;
            m_addr = '0; m_data = '0; m_wcnt = 0;
            m_q.delete(); m_pix.delete();
        end else begin
            m_n   = m_q.size();
            m_pop = (m_n > 0) && !ram_busy;
            m_fd  = frame_start;
            m_req = m_pop;
            if (m_pop) begin
                {m_addr, m_data} = m_q.pop_front();
                exp_log.push_back({m_addr, m_data});
            end
            if (frame_start) begin
                m_lf = hdr_en ? (m_lf + 1) % 6 : 0;
                m_pix.delete();
                m_wcnt = 0;
                m_ovf  = 0;
            end else if (pixel_valid) begin
                if (m_wcnt == WPF) begin
                    m_ovf = 1;
                end else begin
                    m_pix.push_back(pixel_data);
                    if (m_pix.size() == 8) begin
                        for (int k = 0; k < 8; k++) m_word[16*k +: 16] = m_pix[k];
                        if (m_n == 4 && !m_pop) m_ovf = 1;
                        else m_q.push_back({25'(m_lf * int'(SPAN) + 4 * m_wcnt), m_word});
                        m_wcnt++;
                        m_pix.delete();
                    end
                end
            end
        end
    end

    always @(negedge clk_133M) begin
        if (rst_n_133M) begin
            chk("wr_req", 153'(camera_wr_req), 153'(m_req));
            if (m_req) chk("wr_word", {wr_address, camera_data}, {m_addr, m_data});
            if (camera_wr_req) act_log.push_back({wr_address, camera_data});
            if (frame_done_133M) fd_cnt++;
            chk("last_frame", 153'(last_frame), 153'(m_lf));
            chk("exposure_sel", 153'(exposure_sel), 153'(m_lf % 3));
            chk("frame_done", 153'(frame_done_133M), 153'(m_fd));
            chk("overflow", 153'(overflow), 153'(m_ovf));
        end
    end

    task automatic step(input bit fs, input bit pv, input logic [15:0] pd, input bit busy);
        @(posedge clk_133M);
        #2;
        frame_start = fs; pixel_valid = pv; pixel_data = pd; ram_busy = busy;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 16'h0, 0);
    endtask

    task automatic do_reset();
        #1;
        rst_n_133M = 1'b0;
        frame_start = 0; pixel_valid = 0; ram_busy = 0;
        repeat (2) @(posedge clk_133M);
        #2;
        chk("rst_out", {camera_wr_req, wr_address, camera_data}, '0);
        chk("rst_state", 153'({last_frame, exposure_sel, frame_done_133M, overflow}), '0);
        rst_n_133M = 1'b1;
    endtask

    int           lf_tab[7] = '{1, 2, 3, 4, 5, 0, 1};
    int           ex_tab[7] = '{1, 2, 0, 1, 2, 0, 1};
    logic [24:0]  ad_tab[7] = '{25'h25800, 25'h4B000, 25'h70800, 25'h96000, 25'hBB800, 25'h0, 25'h25800};
    logic [15:0]  px[8];
    logic [127:0] word;

    initial begin
        // Test 1: two words into buffer 1
        do_reset();
        hdr_en = 1; fd_cnt = 0;
        act_log.delete(); exp_log.delete();
        step(1, 0, 0, 0);
        for (int i = 1; i <= 16; i++) step(0, 1, 16'(i), 0);
        idle(6);
        chk("t1_nstrobe", 153'(act_log.size()), 153'(2));
        chk("t1_model_n", 153'(exp_log.size()), 153'(2));
        chk("t1_fd_cnt", 153'(fd_cnt), 153'(1));
        chk("t1_lf", 153'(last_frame), 153'(1));
        if (act_log.size() >= 2) begin
            chk("t1_w0", act_log[0], {25'h25800, 128'h0008_0007_0006_0005_0004_0003_0002_0001});
            chk("t1_w1", act_log[1], {25'h25804, 128'h0010_000f_000e_000d_000c_000b_000a_0009});
        end
        if (exp_log.size() >= 2) begin
            chk("t1_model_w0", exp_log[0], {25'h25800, 128'h0008_0007_0006_0005_0004_0003_0002_0001});
            chk("t1_model_w1", exp_log[1], {25'h25804, 128'h0010_000f_000e_000d_000c_000b_000a_0009});
        end

        // Test 2: seven rotations
        do_reset();
        hdr_en = 1;
        for (int f = 0; f < 7; f++) begin
            act_log.delete();
            step(1, 0, 0, 0);
            for (int i = 0; i < 8; i++) step(0, 1, 16'($urandom_range(0, 65535)), 0);
            idle(4);
            chk("t2_lf", 153'(last_frame), 153'(lf_tab[f]));
            chk("t2_exp", 153'(exposure_sel), 153'(ex_tab[f]));
            chk("t2_n", 153'(act_log.size()), 153'(1));
            if (act_log.size() >= 1) chk("t2_addr", 153'(act_log[0][152:128]), 153'(ad_tab[f]));
        end

        // Test 3: busy RAM, fifth word dropped (buffer 2)
        act_log.delete();
        step(1, 0, 0, 1);
        for (int i = 0; i < 40; i++) step(0, 1, 16'($urandom_range(0, 65535)), 1);
        step(0, 0, 0, 1); step(0, 0, 0, 1);
        chk("t3_ovf", 153'(overflow), 153'(1));
        chk("t3_nostrobe", 153'(act_log.size()), 153'(0));
        idle(6);
        for (int i = 0; i < 8; i++) step(0, 1, 16'($urandom_range(0, 65535)), 0);
        idle(4);
        chk("t3_n", 153'(act_log.size()), 153'(5));
        for (int i = 0; i < act_log.size() && i < 5; i++)
            chk("t3_addr", 153'(act_log[i][152:128]), 153'(25'h4B000 + 25'(4 * i + (i == 4 ? 4 : 0))));

        // Test 4: partial word discarded by frame_start (buffer 3)
        act_log.delete();
        for (int i = 0; i < 3; i++) step(0, 1, 16'hdead, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            px[i] = 16'($urandom_range(0, 65535));
            word[16*i +: 16] = px[i];
            step(0, 1, px[i], 0);
        end
        idle(4);
        chk("t4_n", 153'(act_log.size()), 153'(1));
        if (act_log.size() >= 1) chk("t4_word", act_log[0], {25'h70800, word});

        // Test 5: full frame plus extras (buffer 4)
        step(1, 0, 0, 0);
        act_log.delete();
        for (int i = 0; i < WPF * 8 + 8; i++) step(0, 1, 16'($urandom_range(0, 65535)), 0);
        idle(8);
        chk("t5_n", 153'(act_log.size()), 153'(WPF));
        if (act_log.size() >= 1) chk("t5_last", 153'(act_log[act_log.size() - 1][152:128]), 153'(25'h9609C));
        chk("t5_ovf", 153'(overflow), 153'(1));

        // Test 6: hdr disabled
        hdr_en = 0; fd_cnt = 0;
        for (int f = 0; f < 2; f++) begin
            act_log.delete();
            step(1, 0, 0, 0);
            for (int i = 0; i < 8; i++) step(0, 1, 16'($urandom_range(0, 65535)), 0);
            idle(4);
            chk("t6_lf", 153'(last_frame), 153'(0));
            if (act_log.size() >= 1) chk("t6_addr", 153'(act_log[0][152:128]), 153'(0));
            else chk("t6_n", 153'(act_log.size()), 153'(1));
        end
        chk("t6_fd_cnt", 153'(fd_cnt), 153'(2));

        // Test 7: random traffic with occasional resets
        hdr_en = 1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 299) == 0) hdr_en = ~hdr_en;
            if ($urandom_range(0, 1999) == 0) do_reset();
            step($urandom_range(0, 149) == 0, $urandom_range(0, 9) < 7,
                 16'($urandom_range(0, 65535)), $urandom_range(0, 9) < 3);
        end
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
